// File: rtl/cpu_sequencer_pkg.sv
// Shared types and defaults for the multi-cycle instruction sequencer.
// STATE encoding is visible on the debug port, so the enum values are fixed.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ILLEGAL = 2'd1,
    FC_IMEM_TO = 2'd2,
    FC_DMEM_TO = 2'd3
  } fault_code_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle of memory handshakes, decoder flags and control strobes around the sequencer.
// STEP exists only when CPU_SEQ_STEP_EN is defined.
interface cpu_sequencer_if #(
  parameter int CNT_W = 32
);
  // Handshake: the sequencer raises a REQ and holds it (and DMEM_WE) stable until
  // the matching ACK is sampled high on a rising edge; that edge completes the
  // transfer. An ACK while the matching REQ is low is ignored.
  logic             IMEM_REQ;
  logic             IMEM_ACK;
  logic             DMEM_REQ;
  logic             DMEM_WE;
  logic             DMEM_ACK;
  logic             IS_LOAD;
  logic             IS_STORE;
  logic             RD_WRITE;
  logic             ILLEGAL;
  logic             INST_ENB;
  logic             READ_ENB;
  logic             WRITE_ENB;
  logic             PC_CLK;
  logic             FAULT;
  logic [1:0]       FAULT_CODE;
  logic [CNT_W-1:0] RET_CNT;
  logic [2:0]       STATE;
`ifdef CPU_SEQ_STEP_EN
  logic             STEP;
`endif

  modport master (
`ifdef CPU_SEQ_STEP_EN
    input  STEP,
`endif
    input  IMEM_ACK, DMEM_ACK, IS_LOAD, IS_STORE, RD_WRITE, ILLEGAL,
    output IMEM_REQ, DMEM_REQ, DMEM_WE, INST_ENB, READ_ENB, WRITE_ENB, PC_CLK,
    output FAULT, FAULT_CODE, RET_CNT, STATE
  );

  modport slave (
`ifdef CPU_SEQ_STEP_EN
    output STEP,
`endif
    output IMEM_ACK, DMEM_ACK, IS_LOAD, IS_STORE, RD_WRITE, ILLEGAL,
    input  IMEM_REQ, DMEM_REQ, DMEM_WE, INST_ENB, READ_ENB, WRITE_ENB, PC_CLK,
    input  FAULT, FAULT_CODE, RET_CNT, STATE
  );

endinterface

// File: rtl/cpu_sequencer_watchdog.sv
// Memory-wait watchdog shared by FETCH and MEM; TIMEOUT=0 disables it.
// expired fires in the cycle the count would reach TIMEOUT, unless ack is high then.
module seq_watchdog
  import cpu_seq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !ack && cnt_q != LIM) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && enable && !ack && (cnt_q == LIM);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with watchdog, sticky fault and retire counter.
// Define CPU_SEQ_STEP_EN to add single-step: a HALT state after each WB, released by STEP.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  cpu_sequencer_if.master  bus
);

`ifdef CPU_SEQ_STEP_EN
  localparam seq_state_t RESET_STATE = S_HALT;
`else
  localparam seq_state_t RESET_STATE = S_FETCH;
`endif

  seq_state_t       state_q, state_d;
  fault_code_t      fc_q, fc_d;
  logic             ld_q, st_q, rd_q;
  logic             rst_q;
  logic [CNT_W-1:0] ret_q;
  logic             wd_en, wd_exp, wd_ack;
  logic             imem_req, dmem_req, dmem_we, inst_enb, read_enb, write_enb, pc_clk;

  always_ff @(posedge CLK) begin
    rst_q <= RST;
    if (RST) begin
      state_q <= RESET_STATE;
      fc_q    <= FC_NONE;
      ret_q   <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      if (state_q == S_DECODE) begin
        // Load wins when the decoder flags both load and store.
        ld_q <= bus.IS_LOAD;
        st_q <= bus.IS_STORE & ~bus.IS_LOAD;
        rd_q <= bus.RD_WRITE;
      end
      if (state_q == S_WB) ret_q <= ret_q + CNT_W'(1);
    end
  end

  // rst_q marks the cycle after a reset edge: everything stays quiet and the FSM holds.
  assign wd_en  = !rst_q && (state_q == S_FETCH || state_q == S_MEM);
  assign wd_ack = (state_q == S_MEM) ? bus.DMEM_ACK : bus.IMEM_ACK;

  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    inst_enb  = 1'b0;
    read_enb  = 1'b0;
    write_enb = 1'b0;
    pc_clk    = 1'b0;
    if (!rst_q) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (bus.IMEM_ACK) state_d = S_DECODE;
          else if (wd_exp) begin
            state_d = S_FAULT;
            fc_d    = FC_IMEM_TO;
          end
        end
        S_DECODE: begin
          inst_enb = 1'b1;
          if (bus.ILLEGAL) begin
            state_d = S_FAULT;
            fc_d    = FC_ILLEGAL;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: state_d = (ld_q || st_q) ? S_MEM : S_WB;
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = st_q;
          if (bus.DMEM_ACK) state_d = S_WB;
          else if (wd_exp) begin
            state_d = S_FAULT;
            fc_d    = FC_DMEM_TO;
          end
        end
        S_WB: begin
          pc_clk    = 1'b1;
          read_enb  = ld_q;
          write_enb = rd_q & ~st_q;
`ifdef CPU_SEQ_STEP_EN
          state_d   = S_HALT;
`else
          state_d   = S_FETCH;
`endif
        end
`ifdef CPU_SEQ_STEP_EN
        S_HALT: if (bus.STEP) state_d = S_FETCH;
`endif
        S_FAULT: state_d = S_FAULT;
        default: state_d = RESET_STATE;
      endcase
    end
  end

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (CLK),
    .rst     (RST),
    .clear   (~wd_en),
    .enable  (wd_en),
    .ack     (wd_ack),
    .expired (wd_exp)
  );

  assign bus.IMEM_REQ   = imem_req;
  assign bus.DMEM_REQ   = dmem_req;
  assign bus.DMEM_WE    = dmem_we;
  assign bus.INST_ENB   = inst_enb;
  assign bus.READ_ENB   = read_enb;
  assign bus.WRITE_ENB  = write_enb;
  assign bus.PC_CLK     = pc_clk;
  assign bus.FAULT      = (state_q == S_FAULT);
  assign bus.FAULT_CODE = fc_q;
  assign bus.RET_CNT    = ret_q;
  assign bus.STATE      = state_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction-cycle controller for the single-issue RISC-V datapath.
- Steps every instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB.
- Does the request/acknowledge handshakes with instruction and data memory, and generates the one-cycle strobes the control unit and datapath consume: INST_ENB, READ_ENB, WRITE_ENB, PC_CLK.
- Adds a memory watchdog, a sticky fault state and a retired-instruction counter.

Parameters:
- TIMEOUT, 255, max wait cycles for IMEM_ACK/DMEM_ACK before fault; 0 disables the watchdog.
- CNT_W, 32, width of RET_CNT.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- IMEM_ACK  in  1  instruction memory has valid data on MEM_INST
- DMEM_ACK  in  1  data memory access complete
- IS_LOAD  in  1  decoder: instruction is a load, valid during DECODE
- IS_STORE  in  1  decoder: instruction is a store, valid during DECODE
- RD_WRITE  in  1  decoder: instruction writes rd, valid during DECODE
- ILLEGAL  in  1  decoder: unknown opcode, valid during DECODE
- IMEM_REQ  out  1  instruction fetch request
- DMEM_REQ  out  1  data memory request
- DMEM_WE  out  1  data memory write (store)
- INST_ENB  out  1  one-cycle strobe: latch/decode MEM_INST
- READ_ENB  out  1  one-cycle strobe: load data valid
- WRITE_ENB  out  1  one-cycle register-file write strobe
- PC_CLK  out  1  one-cycle PC update strobe
- FAULT  out  1  sticky fault flag
- FAULT_CODE  out  2  0 none, 1 illegal opcode, 2 IMEM timeout, 3 DMEM timeout
- RET_CNT  out  CNT_W  retired-instruction count
- STATE  out  3  current state encoding, for debug

Behaviour:
- Outputs are decoded from the state register and the latched flags only. No combinational path from any input to any output.
- Reset (RST=1 at a rising edge):
  - state=FETCH, FAULT=0, FAULT_CODE=0, RET_CNT=0, latched flags cleared, watchdog counter=0.
  - All strobes and requests are 0 during the reset cycle.
  - Reset mid-operation aborts the access in flight; a request dropping without ACK is legal.
- FETCH: IMEM_REQ=1. On IMEM_ACK -> DECODE.
- DECODE: INST_ENB=1 for exactly one cycle.
  - Latch IS_LOAD, IS_STORE, RD_WRITE.
  - If ILLEGAL=1 -> FAULT with code 1; otherwise -> EXEC.
- EXEC: one cycle, no strobes. Load or store latched -> MEM; otherwise -> WB.
- MEM: DMEM_REQ=1 and DMEM_WE=store flag, held until DMEM_ACK.
  - On ACK -> WB.
  - For a load, READ_ENB=1 during the first WB cycle.
- WB (one cycle):
  - WRITE_ENB = RD_WRITE & ~store.
  - PC_CLK=1.
  - RET_CNT increments, wrapping modulo 2^CNT_W.
  - -> FETCH.
- Requests hold stable until ACK. ACK in any non-requesting state is ignored. IS_LOAD and IS_STORE both high is treated as a load.
- Watchdog:
  - Counter clears on entry to FETCH or MEM and increments each cycle without ACK.
  - Reaching TIMEOUT -> FAULT with code 2 (FETCH) or 3 (MEM).
  - ACK in the same cycle the counter reaches TIMEOUT: ACK wins, no fault.
- FAULT state:
  - All requests and strobes are 0.
  - FAULT=1 and FAULT_CODE hold until RST.
  - RET_CNT frozen.
- Latency with zero-wait ACK (ACK in the first request cycle):
  - ALU, branch or jump instruction: 4 cycles, FETCH-DECODE-EXEC-WB.
  - Load or store: 5 cycles.
- STATE encoding: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT, 7 FAULT.

Optional Feature:
- Macro: CPU_SEQ_STEP_EN.
- When defined:
  - Adds input STEP (1 bit) and state HALT.
  - WB -> HALT instead of FETCH. HALT -> FETCH on STEP=1, sampled at a rising edge.
  - After reset the sequencer starts in HALT.
  - STEP in any other state is ignored.
- When undefined: no STEP port, no HALT state, WB -> FETCH, reset enters FETCH.

Decomposition:
- Package cpu_seq_pkg holds:
  - seq_state_t enum with the STATE encoding above.
  - fault_code_t with FC_NONE, FC_ILLEGAL, FC_IMEM_TO, FC_DMEM_TO.
  - Default TIMEOUT constant.
- Sub-module seq_watchdog:
  - Inputs: clear, enable, ack.
  - Outputs: expired.
  - Parameter: TIMEOUT.
  - Instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset, then ADD with IMEM_ACK in the first FETCH cycle -> INST_ENB at cycle 2, WRITE_ENB and PC_CLK at cycle 4, RET_CNT=1, back to FETCH at cycle 5.
- LW with IMEM_ACK after 3 wait cycles and DMEM_ACK after 2 -> DMEM_REQ=1 and DMEM_WE=0 for 3 cycles; READ_ENB, WRITE_ENB and PC_CLK in the same cycle.
- SW with RD_WRITE=1 -> DMEM_WE=1 in MEM, WRITE_ENB=0 in WB, PC_CLK=1.
- TIMEOUT=4, IMEM_ACK never asserted -> FAULT=1 and FAULT_CODE=2 after 4 FETCH cycles; stays there; RST clears.
- ILLEGAL=1 in DECODE -> FAULT_CODE=1, no PC_CLK.
- RET_CNT with CNT_W=4 wraps 15 -> 0.
- With CPU_SEQ_STEP_EN defined: the sequencer stays in HALT and no request is issued until STEP is pulsed.
